pl9823_chain_driver: RTL
========================

// Module: pl9823_chain_driver
// PURPOSE
//  Parametrised serial driver for a daisy chain of N_LEDS PL9823 RGB LEDs on a single data line.
//  Holds one 24-bit {R,G,B} word per LED, written through a simple write port.
//  Sends frames on request (start/busy/done) or in continuous auto-refresh mode.
//  Sits between the register/control logic and the LED output pin.
// PARAMETERS
//  N_LEDS       3     LEDs in chain (>=1)
//  T0H_CYC      18    clk cycles dout high for a '0' bit (0.36us @50MHz)
//  T1H_CYC      68    clk cycles dout high for a '1' bit (1.36us @50MHz)
//  TBIT_CYC     86    clk cycles per bit; requires T0H_CYC < T1H_CYC < TBIT_CYC
//  TRESET_CYC   2600  clk cycles dout low for latch/reset (>=52us @50MHz)
//  AUTO_REFRESH 0     1 = restart a frame from IDLE without waiting for start
// PORTS
//  clk      in   1                clock, 50MHz nominal
//  rst_n    in   1                asynchronous active-low reset
//  wr_en    in   1                write pixel word this cycle
//  wr_addr  in   AW=max(1,clog2(N_LEDS))  LED index; 0 = first LED on chain
//  wr_data  in   24               {R[7:0],G[7:0],B[7:0]}
//  start    in   1                request one frame; sampled only in IDLE
//  busy     out  1                high from frame/latch start until done
//  done     out  1                one-cycle pulse at end of latch period
//  dout     out  1                serial line to DIN of first LED
// BEHAVIOUR
//  Reset (async assert): dout=0, busy=0, done=0, all pixel words=0, FSM=INIT_LATCH.
//  INIT_LATCH after reset release: dout low for TRESET_CYC cycles, busy=1, no done pulse, then IDLE.
//    Any partial frame cut off by reset is therefore always terminated by a valid latch.
//  IDLE: busy=0, dout=0. start=1 at edge k (or AUTO_REFRESH=1) -> LOAD at k+1, busy=1 from k+1.
//  LOAD (1 cycle): copy pixel[led_idx] into 24-bit shift reg, bit_cnt=23; dout rises at next edge.
//  BIT: bit counter runs 0..TBIT_CYC-1.
//    dout=1 while cnt < (msb ? T1H_CYC : T0H_CYC), else 0.
//    At cnt=TBIT_CYC-1: shift left, decrement bit_cnt.
//    After bit 0: if led_idx<N_LEDS-1, led_idx++ and go to next pixel, else LATCH.
//    The next pixel is loaded with no gap: the last BIT cycle reloads the shift reg, so bit
//    periods are contiguous and there is no extra LOAD cycle between LEDs.
//  Bit order: R7..R0, G7..G0, B7..B0, MSB first; LED 0 first.
//  Frame length: N_LEDS*24*TBIT_CYC + 1 (LOAD) + TRESET_CYC cycles.
//  LATCH: dout=0 for TRESET_CYC cycles.
//    Last cycle: done=1 for exactly one cycle, then IDLE; busy falls with the done cycle+1.
//  start while busy is ignored, not queued. start and done in the same cycle: start ignored.
//  Writes are accepted in every state.
//    A pixel is sampled when it is loaded, so a write to an LED not yet sent shows in the
//    current frame; a write to an already-sent LED shows in the next frame.
//  Write and load of the same pixel in the same cycle: the old value is loaded.
//  wr_addr >= N_LEDS: write ignored.
//  Counters wrap never: all counters reset to 0 on state entry; widths from clog2 of max count.
// STRUCTURE
//  pl9823_defs.vh: default timing localparams (T0H/T1H/TBIT/TRESET for 50MHz), state encodings
//    IDLE/LOAD/BIT/LATCH/INIT_LATCH, the 24-bit colour field offsets.
//  Sub-module pl9823_bit_tx: bit-period counter plus high-time compare.
//    Inputs bit_val and go; outputs dout and bit_end.
//  Top level holds the FSM, pixel array, shift reg, led_idx and bit_cnt.
// TESTING
//  Reset: rst_n=0 mid-bit -> dout=0, busy=0 immediately; after release busy=1 for 2600 cycles,
//    dout=0, no done pulse.
//  Single frame N_LEDS=3, pixel0=0x020000, others 0, start 1 cycle -> 72 bits.
//    Bit 6 high 68 cycles, all others high 18 cycles; each bit 86 cycles.
//    Then 2600 low cycles and one done pulse.
//  Frame-length check: busy high exactly 3*24*86+1+2600 = 8793 cycles from start; start during
//    busy -> no second frame.
//  Write races: write pixel2=0xFFFFFF while pixel0 is sending -> sent in the same frame.
//    Write pixel0=0xFFFFFF while pixel1 is sending -> pixel0 in the current frame stays 0x020000.
//  Address guard: wr_addr=3 with N_LEDS=3 -> no pixel changes; next frame identical to previous.
//  AUTO_REFRESH=1, N_LEDS=1 -> back-to-back frames with done pulse spacing 1*24*86+1+2600 =
//    4665 cycles, dout low only in latch gaps.

Source files
------------

// File: rtl/pl9823_chain_driver_pkg.sv
// Shared definitions for the PL9823 chain driver: default 50 MHz timing,
// pixel field layout and FSM state encoding.
package pl9823_chain_driver_pkg;

  localparam int PIXEL_W = 24;
  localparam int R_LSB   = 16;
  localparam int G_LSB   = 8;
  localparam int B_LSB   = 0;

  localparam int T0H_CYC_DEF    = 18;
  localparam int T1H_CYC_DEF    = 68;
  localparam int TBIT_CYC_DEF   = 86;
  localparam int TRESET_CYC_DEF = 2600;

  localparam int BIT_CNT_W = $clog2(PIXEL_W);

  typedef enum logic [2:0] {
    ST_INIT_LATCH,
    ST_IDLE,
    ST_LOAD,
    ST_BIT,
    ST_LATCH
  } state_e;

  function automatic logic [PIXEL_W-1:0] pack_rgb(input logic [7:0] r,
                                                  input logic [7:0] g,
                                                  input logic [7:0] b);
    logic [PIXEL_W-1:0] w;
    w = '0;
    w[R_LSB +: 8] = r;
    w[G_LSB +: 8] = g;
    w[B_LSB +: 8] = b;
    return w;
  endfunction

endpackage

// File: rtl/pl9823_chain_driver_bit_tx.sv
// One PL9823 bit period: free-running period counter while go is high and
// high-time compare selected by the bit value being sent.
module pl9823_chain_driver_bit_tx
  import pl9823_chain_driver_pkg::*;
#(
  parameter int T0H_CYC  = T0H_CYC_DEF,
  parameter int T1H_CYC  = T1H_CYC_DEF,
  parameter int TBIT_CYC = TBIT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go,
  input  logic bit_val,
  output logic dout,
  output logic bit_end
);

  localparam int CW = $clog2(TBIT_CYC);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] high_cyc;

  assign high_cyc = bit_val ? CW'(T1H_CYC) : CW'(T0H_CYC);
  assign bit_end  = go && (cnt_q == CW'(TBIT_CYC - 1));
  assign dout     = go && (cnt_q < high_cyc);

  // Wrapping at bit_end keeps consecutive bits contiguous while go stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!go || bit_end) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/pl9823_chain_driver.sv
// Serial driver for a daisy chain of PL9823 RGB LEDs: pixel store, frame
// sequencing FSM and shift register feeding the bit-period transmitter.
//
// state         | meaning
// ST_INIT_LATCH | post-reset latch, line low, busy, no done
// ST_IDLE       | waiting for start (or auto refresh)
// ST_LOAD       | copy pixel[led_idx] into the shift register
// ST_BIT        | sending bits, MSB first, LED 0 first
// ST_LATCH      | line low for the reset/latch time, done on last cycle
module pl9823_chain_driver
  import pl9823_chain_driver_pkg::*;
#(
  parameter int N_LEDS       = 3,
  parameter int T0H_CYC      = T0H_CYC_DEF,
  parameter int T1H_CYC      = T1H_CYC_DEF,
  parameter int TBIT_CYC     = TBIT_CYC_DEF,
  parameter int TRESET_CYC   = TRESET_CYC_DEF,
  parameter bit AUTO_REFRESH = 1'b0,
  localparam int AW          = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [PIXEL_W-1:0] wr_data,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               dout
);

  localparam int LW = $clog2(TRESET_CYC + 1);

  state_e               state_q, state_d;
  logic [LW-1:0]        lat_cnt_q, lat_cnt_d;
  logic [PIXEL_W-1:0]   shift_q, shift_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [AW-1:0]        led_idx_q, led_idx_d, led_nxt;
  logic [PIXEL_W-1:0]   pixel_q [N_LEDS];
  logic                 busy_q;
  logic                 go;
  logic                 bit_end;
  logic                 wr_ok;

  assign led_nxt = led_idx_q + AW'(1);
  assign wr_ok   = wr_en && (32'(wr_addr) < N_LEDS);
  assign busy    = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_LEDS; i++) pixel_q[i] <= '0;
    end else if (wr_ok) begin
      pixel_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = '0;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    led_idx_d = led_idx_q;
    go        = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      // One extra count covers the reset-release cycle, where busy is still low.
      ST_INIT_LATCH: begin
        if (lat_cnt_q == LW'(TRESET_CYC)) state_d = ST_IDLE;
        else lat_cnt_d = lat_cnt_q + LW'(1);
      end
      ST_IDLE: begin
        led_idx_d = '0;
        if (start || AUTO_REFRESH) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shift_d   = pixel_q[led_idx_q];
        bit_cnt_d = BIT_CNT_W'(PIXEL_W - 1);
        state_d   = ST_BIT;
      end
      ST_BIT: begin
        go = 1'b1;
        if (bit_end) begin
          if (bit_cnt_q != '0) begin
            shift_d   = {shift_q[PIXEL_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
          end else if (led_idx_q != AW'(N_LEDS - 1)) begin
            led_idx_d = led_nxt;
            shift_d   = pixel_q[led_nxt];
            bit_cnt_d = BIT_CNT_W'(PIXEL_W - 1);
          end else begin
            state_d = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        if (lat_cnt_q == LW'(TRESET_CYC - 1)) begin
          done      = 1'b1;
          led_idx_d = '0;
          state_d   = AUTO_REFRESH ? ST_LOAD : ST_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q + LW'(1);
        end
      end
      default: state_d = ST_INIT_LATCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT_LATCH;
      lat_cnt_q <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      led_idx_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      led_idx_q <= led_idx_d;
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  pl9823_chain_driver_bit_tx #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .TBIT_CYC(TBIT_CYC)
  ) u_bit_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .go     (go),
    .bit_val(shift_q[PIXEL_W-1]),
    .dout   (dout),
    .bit_end(bit_end)
  );

endmodule
